// File: rtl/prbs_sched_if.sv
// Control-side bundle between the register interface and the PRBS sequencing controller.
// The controller connects through the slave modport; the master modport belongs to whatever drives it.
interface prbs_sched_if #(
   parameter int LEN_W = 16,
   parameter int PH_W  = 2
);
   logic             start;
   logic             stop;
   logic [LEN_W-1:0] burst_len;
   logic [8:0]       seed_i_in;
   logic [8:0]       seed_q_in;
   logic [8:0]       seed_i_o;
   logic [8:0]       seed_q_o;
   logic             load_o;
   logic             en_o;
   logic [PH_W-1:0]  phase_o;
   logic [LEN_W-1:0] sym_cnt_o;
   logic             busy_o;
   logic             done_o;

   modport master (
      output start, stop, burst_len, seed_i_in, seed_q_in,
      input  seed_i_o, seed_q_o, load_o, en_o, phase_o, sym_cnt_o, busy_o, done_o
   );

   modport slave (
      input  start, stop, burst_len, seed_i_in, seed_q_in,
      output seed_i_o, seed_q_o, load_o, en_o, phase_o, sym_cnt_o, busy_o, done_o
   );
endinterface

// File: rtl/prbs_sched.sv
// Burst sequencer for the I/Q PRBS generators: seed load, symbol-rate shift enable
// derived from the oversampled clock, symbol counting and start/stop handling.
module prbs_sched #(
   parameter int N_PHASES = 4,
   parameter int LEN_W    = 16,
   parameter int PH_W     = $clog2(N_PHASES)
) (
   input logic         clk,
   input logic         rst,
   prbs_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_PHASES - 1);

   state_t           state_q, state_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [8:0]       seed_i_q, seed_i_d;
   logic [8:0]       seed_q_q, seed_q_d;
   logic             stop_pend_q, stop_pend_d;
   logic             en;
   logic [LEN_W-1:0] cnt_inc;

   assign en      = (state_q == RUN) && (phase_q == PH_LAST);
   assign cnt_inc = cnt_q + LEN_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         seed_i_q    <= '0;
         seed_q_q    <= '0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         seed_i_q    <= seed_i_d;
         seed_q_q    <= seed_q_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = '0;
      cnt_d       = cnt_q;
      len_d       = len_q;
      seed_i_d    = seed_i_q;
      seed_q_d    = seed_q_q;
      stop_pend_d = stop_pend_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               len_d    = bus.burst_len;
               seed_i_d = bus.seed_i_in;
               seed_q_d = bus.seed_q_in;
               cnt_d    = '0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            stop_pend_d = 1'b0;
            state_d     = RUN;
         end
         RUN: begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            if (bus.stop) stop_pend_d = 1'b1;
            // A stop seen on the enable cycle itself ends the burst at this symbol boundary.
            if (en) begin
               cnt_d = cnt_inc;
               if (stop_pend_q || bus.stop || ((len_q != '0) && (cnt_inc == len_q)))
                  state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.seed_i_o  = seed_i_q;
   assign bus.seed_q_o  = seed_q_q;
   assign bus.load_o    = (state_q == LOAD);
   assign bus.en_o      = en;
   assign bus.phase_o   = phase_q;
   assign bus.sym_cnt_o = cnt_q;
   assign bus.busy_o    = (state_q != IDLE);
   assign bus.done_o    = (state_q == DONE);
endmodule

// File: tb/tb_prbs_sched.sv
// Bench for prbs_sched: directed burst table, hand sequences for restart/wrap/reset,
// and randomized start/stop traffic against a burst-timing reference model.
module tb_prbs_sched;
   localparam int N   = 4;
   localparam int LW  = 4;
   localparam int PW  = 2;
   localparam int INF = 1 << 20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   prbs_sched_if #(.LEN_W(LW), .PH_W(PW)) bus ();
   prbs_sched #(.N_PHASES(N), .LEN_W(LW), .PH_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a burst is described by the edge count since its start edge
   // and the number of symbols it will emit (m_end), both derived from the rules.
   bit         m_act;
   int         m_t;
   int         m_end;
   int         m_cnt;
   logic [8:0] m_si, m_sq;

   function automatic void model_reset();
      m_act = 1'b0; m_t = 0; m_end = INF; m_cnt = 0; m_si = '0; m_sq = '0;
   endfunction

   function automatic void model_edge(logic st, logic sp, logic [LW-1:0] len,
                                      logic [8:0] si, logic [8:0] sq);
      int m;
      if (!m_act) begin
         if (st) begin
            m_act = 1'b1; m_t = 0; m_cnt = 0; m_si = si; m_sq = sq;
            m_end = (len == '0) ? INF : int'(len);
         end
      end else begin
         m_t++;
         // stop sampled while running ends the burst at the next symbol boundary (edge m*N+1)
         if (sp && m_t >= 2 && m_t <= m_end * N + 1) begin
            m = (m_t - 1 + N - 1) / N;
            if (m < m_end) m_end = m;
         end
         m_cnt = ((m_t - 1) / N < m_end) ? (m_t - 1) / N : m_end;
         if (m_t == m_end * N + 2) m_act = 1'b0;
      end
   endfunction

   function automatic logic [27:0] model_out();
      logic          ld, en, bsy, dn;
      logic [PW-1:0] ph;
      ld  = m_act && (m_t == 0);
      bsy = m_act;
      en  = m_act && (m_t >= N) && ((m_t % N) == 0) && (m_t <= m_end * N);
      dn  = m_act && (m_t == m_end * N + 1);
      ph  = (m_act && m_t >= 1 && m_t <= m_end * N) ? PW'((m_t - 1) % N) : '0;
      return {m_si, m_sq, ld, en, ph, LW'(m_cnt), bsy, dn};
   endfunction

   function automatic logic [27:0] dut_out();
      return {bus.seed_i_o, bus.seed_q_o, bus.load_o, bus.en_o, bus.phase_o,
              bus.sym_cnt_o, bus.busy_o, bus.done_o};
   endfunction

   task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h {si,sq,load,en,ph,cnt,busy,done}",
                  name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(bus.start, bus.stop, bus.burst_len, bus.seed_i_in, bus.seed_q_in);
      #1;
      check("cycle", dut_out(), model_out());
   endtask

   typedef struct {
      logic [LW-1:0] len;
      logic [8:0]    si;
      logic [8:0]    sq;
      int            stop_edge;
      int            done_edge;
      int            sym;
   } vec_t;

   vec_t tbl[6];

   task automatic run_vec(input vec_t v);
      int done_at;
      done_at = -1;
      bus.start = 1'b1; bus.burst_len = v.len; bus.seed_i_in = v.si; bus.seed_q_in = v.sq;
      step();
      bus.start = 1'b0;
      for (int e = 1; e <= 80; e++) begin
         bus.stop = (e == v.stop_edge);
         step();
         if (bus.done_o === 1'b1) done_at = e;
         if (bus.busy_o !== 1'b1) break;
      end
      bus.stop = 1'b0;
      check_int("done_edge", done_at, v.done_edge);
      check_int("final_sym", int'(bus.sym_cnt_o), v.sym);
   endtask

   task automatic drain();
      bus.start = 1'b0;
      for (int e = 0; e < 60; e++) begin
         if (bus.busy_o !== 1'b1) break;
         bus.stop = 1'b1;
         step();
      end
      bus.stop = 1'b0;
      check_int("drained_idle", int'(bus.busy_o), 0);
   endtask

   initial begin
      int load2;
      tbl[0] = '{4'd3,  9'h1AA, 9'h0F0, 0,  13, 3};  // plain finite burst
      tbl[1] = '{4'd0,  9'h055, 9'h100, 7,  9,  2};  // early stop, continuous
      tbl[2] = '{4'd2,  9'h001, 9'h1FF, 9,  9,  2};  // stop coincides with final en
      tbl[3] = '{4'd1,  9'h123, 9'h0AB, 0,  5,  1};  // single symbol
      tbl[4] = '{4'd5,  9'h0C3, 9'h13C, 2,  5,  1};  // stop on first RUN cycle
      tbl[5] = '{4'd15, 9'h1FE, 9'h002, 14, 17, 4};  // stop mid-symbol, long burst

      rst = 1'b1;
      bus.start = 1'b0; bus.stop = 1'b0; bus.burst_len = '0;
      bus.seed_i_in = '0; bus.seed_q_in = '0;
      model_reset();
      @(posedge clk); #1;
      check("reset_state", dut_out(), 28'h0);
      @(negedge clk); rst = 1'b0;

      foreach (tbl[i]) begin
         run_vec(tbl[i]);
         step();
      end

      // start held through a whole burst: next load only after the first IDLE cycle
      load2 = -1;
      bus.start = 1'b1; bus.burst_len = 4'd2; bus.seed_i_in = 9'h0AA; bus.seed_q_in = 9'h155;
      step();
      for (int e = 1; e <= 30; e++) begin
         step();
         if (bus.load_o === 1'b1) begin load2 = e; break; end
      end
      check_int("restart_load_edge", load2, 11);
      drain();

      // continuous burst: counter wraps 15 -> 0 -> 1 with no done
      bus.start = 1'b1; bus.burst_len = '0; bus.seed_i_in = 9'h1C7; bus.seed_q_in = 9'h038;
      step();
      bus.start = 1'b0;
      for (int e = 1; e <= 70; e++) begin
         step();
         if (e == 61) check_int("wrap_cnt15", int'(bus.sym_cnt_o), 15);
         if (e == 65) check_int("wrap_cnt0", int'(bus.sym_cnt_o), 0);
         if (e == 69) check_int("wrap_cnt1", int'(bus.sym_cnt_o), 1);
      end
      drain();

      // asynchronous reset in the middle of a burst
      bus.start = 1'b1; bus.burst_len = 4'd3; bus.seed_i_in = 9'h111; bus.seed_q_in = 9'h0EE;
      step();
      bus.start = 1'b0;
      for (int e = 0; e < 5; e++) step();
      #3 rst = 1'b1;
      #1;
      model_reset();
      check("reset_async", dut_out(), 28'h0);
      @(posedge clk); #1;
      check("reset_hold", dut_out(), 28'h0);
      @(negedge clk); rst = 1'b0;
      step();

      for (int c = 0; c < 600; c++) begin
         bus.start     = ($urandom % 4) == 0;
         bus.stop      = ($urandom % 10) == 0;
         bus.burst_len = LW'($urandom % 6);
         bus.seed_i_in = 9'($urandom);
         bus.seed_q_in = 9'($urandom);
         step();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
